combination_entry: RTL

- Keypad-side front end for the combination lock FSM. It collects digit keystrokes into an entry buffer and holds the stored combination.
- It drives the lock's `correct` input. It consumes the lock's `new` output (programming mode) to load a new combination.
- Shares `enter`/`change` pulses with the lock; sits between the keypad scanner and the lock FSM.

---
 rtl/combination_entry_pkg.sv | 19 +
 rtl/combination_entry_digit_shift_buffer.sv | 75 +++++++
 rtl/combination_entry.sv | 70 +++++++
 3 files changed

// File: rtl/combination_entry_pkg.sv
// Shared constants and types for the combination lock keypad front end.
package combination_entry_pkg;

  localparam int unsigned LOCK_DIGITS    = 4;
  localparam int unsigned LOCK_DIGIT_W   = 4;
  localparam int unsigned LOCK_MAX_DIGIT = 9;
  localparam int unsigned LOCK_CODE_W    = LOCK_DIGITS * LOCK_DIGIT_W;

  localparam logic [LOCK_CODE_W-1:0] LOCK_DEFAULT_CODE = 16'h1234;

  // What the entry buffer does at a given clock edge, highest priority first
  typedef enum logic [1:0] {
    EV_NONE,
    EV_FLUSH,
    EV_CLEAR,
    EV_DIGIT
  } edge_event_e;

endpackage

// File: rtl/combination_entry_digit_shift_buffer.sv
// Digit entry buffer: shifts accepted digits in from the right, counts them,
// and saturates at DIGITS (further digits are dropped, never wrapped).
module combination_entry_digit_shift_buffer
  import combination_entry_pkg::*;
#(
  parameter int unsigned DIGITS    = LOCK_DIGITS,
  parameter int unsigned DIGIT_W   = LOCK_DIGIT_W,
  parameter int unsigned MAX_DIGIT = LOCK_MAX_DIGIT
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           key_clear,
  input  logic                           key_valid,
  input  logic [DIGIT_W-1:0]             key_digit,
  output logic [DIGITS*DIGIT_W-1:0]      entry_buf,
  output logic [$clog2(DIGITS+1)-1:0]    digit_count,
  output logic                           entry_full
);

  localparam int unsigned CODE_W = DIGITS * DIGIT_W;
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1);

  localparam logic [DIGIT_W-1:0] MAX_DIGIT_L = DIGIT_W'(MAX_DIGIT);
  localparam logic [CNT_W-1:0]   FULL_COUNT  = CNT_W'(DIGITS);

  logic [CODE_W-1:0] entry_buf_q, entry_buf_d;
  logic [CNT_W-1:0]  digit_count_q, digit_count_d;
  logic              full;
  edge_event_e       ev;

  assign full = (digit_count_q == FULL_COUNT);

  // Resolve the edge event by priority, then compute the next buffer and count
  always_comb begin
    ev = EV_NONE;
    if (flush) begin
      ev = EV_FLUSH;
    end else if (key_clear) begin
      ev = EV_CLEAR;
    end else if (key_valid && (key_digit <= MAX_DIGIT_L) && !full) begin
      ev = EV_DIGIT;
    end

    entry_buf_d   = entry_buf_q;
    digit_count_d = digit_count_q;
    case (ev)
      EV_FLUSH, EV_CLEAR: begin
        entry_buf_d   = '0;
        digit_count_d = '0;
      end
      EV_DIGIT: begin
        entry_buf_d   = {entry_buf_q[CODE_W-DIGIT_W-1:0], key_digit};
        digit_count_d = digit_count_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Register buffer and count
  always_ff @(posedge clock) begin
    if (reset) begin
      entry_buf_q   <= '0;
      digit_count_q <= '0;
    end else begin
      entry_buf_q   <= entry_buf_d;
      digit_count_q <= digit_count_d;
    end
  end

  assign entry_buf   = entry_buf_q;
  assign digit_count = digit_count_q;
  assign entry_full  = full;

endmodule

// File: rtl/combination_entry.sv
// Keypad-side front end for the combination lock: holds the stored code,
// compares the entry buffer against it, and commits new codes in
// programming mode.
module combination_entry
  import combination_entry_pkg::*;
#(
  parameter int unsigned                        DIGITS       = LOCK_DIGITS,
  parameter int unsigned                        DIGIT_W      = LOCK_DIGIT_W,
  parameter int unsigned                        MAX_DIGIT    = LOCK_MAX_DIGIT,
  parameter logic [DIGITS*DIGIT_W-1:0]          DEFAULT_CODE = LOCK_DEFAULT_CODE
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        key_valid,
  input  logic [DIGIT_W-1:0]          key_digit,
  input  logic                        key_clear,
  input  logic                        enter,
  input  logic                        change,
  input  logic                        new_mode,
  output logic                        correct,
  output logic                        entry_full,
  output logic [$clog2(DIGITS+1)-1:0] digit_count,
  output logic                        code_updated
);

  localparam int unsigned CODE_W = DIGITS * DIGIT_W;

  logic [CODE_W-1:0] entry_buf;
  logic [CODE_W-1:0] stored_code_q, stored_code_d;
  logic              code_updated_q, code_updated_d;
  logic              commit;

  combination_entry_digit_shift_buffer #(
    .DIGITS    (DIGITS),
    .DIGIT_W   (DIGIT_W),
    .MAX_DIGIT (MAX_DIGIT)
  ) u_buf (
    .clock       (clock),
    .reset       (reset),
    .flush       (enter | change),
    .key_clear   (key_clear),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .entry_buf   (entry_buf),
    .digit_count (digit_count),
    .entry_full  (entry_full)
  );

  // Commit only a complete entry on enter in programming mode; change aborts
  always_comb begin
    commit         = new_mode && enter && entry_full;
    stored_code_d  = commit ? entry_buf : stored_code_q;
    code_updated_d = commit;
  end

  // Register stored code and the one-cycle commit pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      stored_code_q  <= DEFAULT_CODE;
      code_updated_q <= 1'b0;
    end else begin
      stored_code_q  <= stored_code_d;
      code_updated_q <= code_updated_d;
    end
  end

  assign correct      = entry_full && (entry_buf == stored_code_q);
  assign code_updated = code_updated_q;

endmodule
